// File: rtl/alu_seq.sv
// alu_seq: handshaked, registered ALU with flags, shifts and an iterative
// shift-add unsigned multiplier. Single-cycle ops complete in one cycle;
// MUL takes WIDTH cycles. Results are held stable until consumed.
module alu_seq #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             zf,
    output logic             cf,
    output logic             of,
    output logic             nf,
    output logic             busy
);

    localparam int CW = SHW + 1;

    localparam logic [3:0] op_add = 4'd0;
    localparam logic [3:0] op_sub = 4'd1;
    localparam logic [3:0] op_inc = 4'd2;
    localparam logic [3:0] op_dec = 4'd3;
    localparam logic [3:0] op_and = 4'd4;
    localparam logic [3:0] op_or  = 4'd5;
    localparam logic [3:0] op_not = 4'd6;
    localparam logic [3:0] op_xor = 4'd7;
    localparam logic [3:0] op_shl = 4'd8;
    localparam logic [3:0] op_shr = 4'd9;
    localparam logic [3:0] op_sar = 4'd10;
    localparam logic [3:0] op_mul = 4'd11;

    typedef enum logic [1:0] {s_idle, s_mul, s_done} state_t;

    state_t             state;
    logic               accept;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_cf;
    logic               alu_of;

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [CW-1:0]      count;
    logic               mul_hi_nz;

    assign shamt     = b[SHW-1:0];
    assign add_b     = (opcode == op_inc || opcode == op_dec) ? WIDTH'(1) : b;
    assign accept    = in_valid && in_ready;
    assign acc_next  = acc + (mplier[0] ? mcand : '0);
    assign mul_hi_nz = |acc_next[2*WIDTH-1:WIDTH];

    // Ready is derived from the current state so the upstream can see
    // back-pressure from the consumer in the same cycle.
    always_comb begin
        // NOTE: give every always_comb output a default first; a path that
        // leaves it unassigned would infer a latch.
        in_ready = 1'b0;
        case (state)
            s_idle:  in_ready = enable;
            s_done:  in_ready = enable && out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    // Single-cycle datapath: result plus carry/overflow for every non-MUL op.
    always_comb begin
        alu_res = '0;
        alu_cf  = 1'b0;
        alu_of  = 1'b0;
        case (opcode)
            op_add, op_inc: begin
                {alu_cf, alu_res} = {1'b0, a} + {1'b0, add_b};
                alu_of = (a[WIDTH-1] == add_b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            op_sub, op_dec: begin
                // The extra top bit of the difference is the borrow.
                {alu_cf, alu_res} = {1'b0, a} - {1'b0, add_b};
                alu_of = (a[WIDTH-1] != add_b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            op_and: alu_res = a & b;
            op_or:  alu_res = a | b;
            op_not: alu_res = ~a;
            op_xor: alu_res = a ^ b;
            // A guard bit on the outgoing side catches the last bit shifted
            // out, and stays 0 for a zero shift.
            op_shl: {alu_cf, alu_res} = {1'b0, a} << shamt;
            op_shr: {alu_res, alu_cf} = {a, 1'b0} >> shamt;
            op_sar: {alu_res, alu_cf} = $signed({a, 1'b0}) >>> shamt;
            default: begin
                alu_res = '0;
                alu_cf  = 1'b0;
                alu_of  = 1'b0;
            end
        endcase
    end

    // Control FSM with registered result, flags, out_valid and busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= s_idle;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            res       <= '0;
            zf        <= 1'b0;
            cf        <= 1'b0;
            of        <= 1'b0;
            nf        <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            count     <= '0;
        end else if (accept) begin
            // Accept is possible from IDLE, or from DONE in the same edge
            // that hands the previous result downstream.
            if (opcode == op_mul) begin
                // NOTE: sequential state uses non-blocking assignments so
                // every register samples the pre-edge values.
                mcand     <= {{WIDTH{1'b0}}, a};
                mplier    <= b;
                acc       <= '0;
                count     <= CW'(WIDTH);
                busy      <= 1'b1;
                out_valid <= 1'b0;
                state     <= s_mul;
            end else begin
                res       <= alu_res;
                zf        <= (alu_res == '0);
                cf        <= alu_cf;
                of        <= alu_of;
                nf        <= alu_res[WIDTH-1];
                out_valid <= 1'b1;
                state     <= s_done;
            end
        end else begin
            case (state)
                s_mul: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count - 1'b1;
                    if (count == CW'(1)) begin
                        res       <= acc_next[WIDTH-1:0];
                        zf        <= (acc_next[WIDTH-1:0] == '0);
                        cf        <= mul_hi_nz;
                        of        <= mul_hi_nz;
                        nf        <= acc_next[WIDTH-1];
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= s_done;
                    end
                end
                s_done: begin
                    // Without out_ready the result and flags simply hold.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= s_idle;
                    end
                end
                default: state <= s_idle;
            endcase
        end
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's combinational 32-bit ALU. It adds registered outputs, valid/ready flow control on both sides, shift ops and an iterative unsigned multiplier. It also produces a full flag set (zero, carry, overflow, negative). It sits between an operand-issue stage and a result writeback stage, and accepts one operation per cycle for single-cycle ops.

## Interface
Parameters:
- WIDTH, 32, datapath width; power of two, minimum 8.
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
- clk, input, 1, sole clock; all state updates on rising edge.
- rst, input, 1, reset; asynchronous, active-high.
- enable, input, 1, 0 forces in_ready=0; in-flight op completes and drains normally.
- in_valid, input, 1, operation offered.
- in_ready, output, 1, block can accept; combinational from state, enable, out_ready.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B; shifts use b[SHW-1:0] only.
- opcode, input, 4, operation select.
- out_valid, output, 1, result/flags valid.
- out_ready, input, 1, downstream consumes result.
- res, output, WIDTH, registered result.
- zf, cf, of, nf, output, 1 each, registered zero/carry/signed-overflow/negative flags.
- busy, output, 1, high in MUL state.

## Operation
Opcodes:
- 0 ADD: a+b; cf = carry-out; of = signed overflow.
- 1 SUB: a-b; cf = borrow (a<b unsigned); of = signed overflow.
- 2 INC: a+1; cf = carry-out; of = signed overflow.
- 3 DEC: a-1; cf = borrow (a==0); of = signed overflow.
- 4 AND, 5 OR, 7 XOR: bitwise a op b; cf=of=0.
- 6 NOT: ~a; cf=of=0.
- 8 SHL, 9 SHR (logical), 10 SAR (arithmetic) by s=b[SHW-1:0]:
  - cf = last bit shifted out; cf=0 when s=0.
  - of=0.
- 11 MUL: low WIDTH bits of unsigned a*b; cf=of=1 iff the high WIDTH bits are nonzero.
- 12–15 illegal: res=0; zf=1; cf=of=nf=0.

Flags for all ops: zf = (res==0); nf = res[WIDTH-1].

State machine IDLE / MUL / DONE:
- IDLE: in_ready=enable. On accept (in_valid&&in_ready):
  - single-cycle op: register result and flags, go to DONE.
  - MUL: load multiplicand, multiplier and zeroed 2·WIDTH accumulator; count=WIDTH; go to MUL.
- MUL: in_ready=0. Each cycle performs one shift-add step and decrements count. After the step with count==1, write res/flags and go to DONE.
- DONE: out_valid=1. in_ready = enable && out_ready.
  - out_ready && accept: new op handled as in IDLE, same edge.
  - out_ready && no accept: go to IDLE.
  - !out_ready: hold res and flags bit-stable; stay in DONE.

Boundary conditions:
- in_valid with enable=0: ignored; nothing captured.
- rst asserted at any time, including mid-MUL: immediate return to IDLE; partial product discarded; no out_valid produced for the aborted op.
- Operand inputs are sampled only on the accept edge; later changes to a, b or opcode have no effect.

## Timing
- Reset values: out_valid=0, res=0, zf=0, cf=0, of=0, nf=0, busy=0, state IDLE.
- in_ready after reset equals enable.
- Single-cycle ops: out_valid rises the cycle after the accept edge (latency 1). With out_ready held at 1, throughput is 1 op/cycle.
- MUL: out_valid rises exactly WIDTH cycles after the accept edge (WIDTH=32: 32 cycles).
  - busy=1 and in_ready=0 for those WIDTH cycles.
  - Maximum MUL throughput is 1 op per WIDTH+1 cycles when out_ready=1.
- Handshake: a transfer occurs on an edge where valid&&ready. out_valid never drops without out_ready=1 on that edge.
- No combinational path from a, b or opcode to any output. in_ready depends combinationally on out_ready.

## Test plan
- ADD, WIDTH=32, a=0xFFFFFFFF, b=1 -> res=0x00000000, zf=1, cf=1, of=0, nf=0, one cycle after accept. Then a=0x7FFFFFFF, b=1 -> res=0x80000000, of=1, nf=1, cf=0.
- SUB a=3, b=5 -> res=0xFFFFFFFE, cf=1, nf=1, of=0. SAR a=0x80000001, b=4 -> res=0xF8000000, cf=0. SHL a=0x80000000, b=1 -> res=0, cf=1, zf=1.
- MUL a=0x00010000, b=0x00010000 -> res=0, cf=of=1, out_valid exactly 32 cycles after accept, in_ready=0 throughout. MUL a=123, b=456 -> res=56088, cf=0.
- Back-to-back: 8 ADDs with in_valid and out_ready held at 1 -> 8 results on 8 consecutive cycles. Then out_ready low for 5 cycles -> res/flags frozen, in_ready=0, no op lost or duplicated.
- rst pulsed mid-MUL (cycle 10 of 32) -> all outputs 0 asynchronously; next op accepted normally; no stale result emitted. enable=0 with in_valid=1 -> in_ready=0, no capture.
- Opcode 13 -> res=0, zf=1, cf=of=nf=0. Repeat ADD/MUL checks at WIDTH=8: 0xFF+1 -> cf=1; MUL latency 8.
